// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and rebuilds NDIG hex digits.
// Optional SEG7DEC_STICKY_ERR_EN: err_out accumulates until err_clr or rst.
module seg7_scan_decoder #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
`ifdef SEG7DEC_STICKY_ERR_EN
  input  logic              err_clr,
`endif
  output logic [4*NDIG-1:0] hex_out,
  output logic [NDIG-1:0]   blank_out,
  output logic [NDIG-1:0]   err_out,
  output logic              frame_valid,
  output logic              sel_err
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t state, state_n;

  logic [6:0]      seg_s1, seg_s2, seg_p;
  logic [NDIG-1:0] sel_s1, sel_s2, sel_p;
  logic            multi_q;

  logic [CW-1:0]   cnt, cnt_n;
  logic            cap;
  logic [NDIG-1:0] seen;
  logic            pend;

  logic [3:0]      sh_hex [NDIG];
  logic [NDIG-1:0] sh_blank, sh_err;

  logic [3:0]      nz;
  logic [IW-1:0]   idx;
  logic            onehot, multi, same;
  logic [5:0]      dec;

  // Result packing: {blank, err, hex}
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'h40:   r = {2'b00, 4'h0};
      7'h79:   r = {2'b00, 4'h1};
      7'h24:   r = {2'b00, 4'h2};
      7'h30:   r = {2'b00, 4'h3};
      7'h32:   r = {2'b00, 4'h4};
      7'h19:   r = {2'b00, 4'h4};
      7'h12:   r = {2'b00, 4'h5};
      7'h02:   r = {2'b00, 4'h6};
      7'h78:   r = {2'b00, 4'h7};
      7'h00:   r = {2'b00, 4'h8};
      7'h18:   r = {2'b00, 4'h9};
      7'h10:   r = {2'b00, 4'h9};
      7'h08:   r = {2'b00, 4'hA};
      7'h03:   r = {2'b00, 4'hB};
      7'h27:   r = {2'b00, 4'hC};
      7'h21:   r = {2'b00, 4'hD};
      7'h06:   r = {2'b00, 4'hE};
      7'h0E:   r = {2'b00, 4'hF};
      7'h7F:   r = {2'b10, 4'h0};
      default: r = {2'b01, 4'h0};
    endcase
    return r;
  endfunction

  always_comb begin
    nz  = '0;
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!sel_s2[i]) begin
        nz  = nz + 4'd1;
        idx = IW'(i);
      end
    end
  end

  // All-zero select falls into multi along with any multi-hot pattern
  assign onehot = (nz == 4'd1);
  assign multi  = (nz > 4'd1);
  assign same   = ({seg_s2, sel_s2} == {seg_p, sel_p});
  assign dec    = decode(seg_s2);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    if (!EN || !onehot) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_n   = '0;
          cap     = (cnt_n == LAST);
          state_n = cap ? HOLD : SETTLE;
        end
        SETTLE: begin
          cnt_n   = same ? cnt + CW'(1) : '0;
          cap     = (cnt_n == LAST);
          state_n = cap ? HOLD : SETTLE;
        end
        HOLD: begin
          if (!same) begin
            cnt_n   = '0;
            cap     = (cnt_n == LAST);
            state_n = cap ? HOLD : SETTLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1      <= '1;
      seg_s2      <= '1;
      seg_p       <= '1;
      sel_s1      <= '1;
      sel_s2      <= '1;
      sel_p       <= '1;
      multi_q     <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      seen        <= '0;
      pend        <= 1'b0;
      sh_blank    <= '0;
      sh_err      <= '0;
      for (int i = 0; i < NDIG; i++) sh_hex[i] <= '0;
      hex_out     <= '0;
      blank_out   <= '1;
      err_out     <= '0;
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      seg_s1      <= seg_in;
      seg_s2      <= seg_s1;
      seg_p       <= seg_s2;
      sel_s1      <= dig_sel;
      sel_s2      <= sel_s1;
      sel_p       <= sel_s2;
      multi_q     <= multi;
      state       <= state_n;
      cnt         <= cnt_n;
      sel_err     <= EN && multi && !multi_q;
      frame_valid <= pend;
      pend        <= 1'b0;

      if (!EN) begin
        seen <= '0;
      end else if (cap) begin
        sh_hex[idx]   <= dec[3:0];
        sh_blank[idx] <= dec[5];
        sh_err[idx]   <= dec[4];
        if ((seen | ~sel_s2) == '1) begin
          seen <= '0;
          pend <= 1'b1;
        end else begin
          seen <= seen | ~sel_s2;
        end
      end

      if (pend) begin
        for (int i = 0; i < NDIG; i++) hex_out[4*i +: 4] <= sh_hex[i];
        blank_out <= sh_blank;
`ifdef SEG7DEC_STICKY_ERR_EN
        err_out   <= err_out | sh_err;
`else
        err_out   <= sh_err;
`endif
      end
`ifdef SEG7DEC_STICKY_ERR_EN
      // Clear takes priority over a frame load in the same cycle
      if (err_clr) err_out <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (NDIG=4, STABLE_CYCLES=3).
// Handles both builds of SEG7DEC_STICKY_ERR_EN.
module tb_seg7_scan_decoder;

  localparam int NDIG = 4;
  localparam int SC   = 3;
`ifdef SEG7DEC_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, EN, err_clr;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] hex_out;
  logic [3:0]  blank_out, err_out;
  logic        frame_valid, sel_err;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYCLES(SC)) dut (
    .clk(clk),
    .rst(rst),
    .EN(EN),
    .seg_in(seg_in),
    .dig_sel(dig_sel),
`ifdef SEG7DEC_STICKY_ERR_EN
    .err_clr(err_clr),
`endif
    .hex_out(hex_out),
    .blank_out(blank_out),
    .err_out(err_out),
    .frame_valid(frame_valid),
    .sel_err(sel_err)
  );

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  frame_t exp_q[$];
  frame_t mon_f;
  int errors = 0;
  int checks = 0;
  int sel_pulses = 0;
  int sel_exp = 0;

  logic [6:0] pat_tab [18] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h32, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h18, 7'h10,
                               7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
  logic [3:0] val_tab [18] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h4,
                               4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'h9,
                               4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  logic [6:0] canon [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h27, 7'h21, 7'h06, 7'h0E};

  logic [3:0]  m_hex [4];
  logic [3:0]  m_blank, m_err, m_seen, m_acc;
  logic        m_en, last_multi;
  logic [10:0] last_bus;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] h,
                                     output logic b, output logic e);
    h = 4'h0; b = 1'b0; e = 1'b0;
    if (p == 7'h7F) begin
      b = 1'b1;
    end else begin
      e = 1'b1;
      for (int k = 0; k < 18; k++)
        if (pat_tab[k] == p) begin
          h = val_tab[k];
          e = 1'b0;
        end
    end
  endfunction

  function automatic logic [3:0] dsel(input int i);
    logic [3:0] s;
    s = 4'hF;
    s[i] = 1'b0;
    return s;
  endfunction

  function automatic int zeros(input logic [3:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (!s[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_hex[i] = 4'h0;
    m_blank = 4'h0; m_err = 4'h0; m_seen = 4'h0; m_acc = 4'h0;
    last_multi = 1'b0;
    last_bus = 11'h7FF;
  endtask

  // Drive one constant bus value for h clocks and predict its effect
  task automatic issue(input logic [3:0] s, input logic [6:0] g, input int h);
    int nz, id;
    logic [3:0] dh;
    logic db, de;
    frame_t f;
    nz = zeros(s);
    if (m_en && nz > 1 && !last_multi) sel_exp++;
    last_multi = (nz > 1);
    if (m_en && nz == 1 && h >= SC) begin
      id = 0;
      for (int i = 0; i < 4; i++) if (!s[i]) id = i;
      ref_decode(g, dh, db, de);
      m_hex[id] = dh; m_blank[id] = db; m_err[id] = de;
      m_seen[id] = 1'b1;
      if (m_seen == 4'hF) begin
        f.hex   = {m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
        f.blank = m_blank;
        f.err   = STICKY ? (m_acc | m_err) : m_err;
        m_acc   = f.err;
        exp_q.push_back(f);
        m_seen  = 4'h0;
      end
    end
    last_bus = {s, g};
    dig_sel = s;
    seg_in  = g;
    repeat (h) @(posedge clk);
    #1;
  endtask

  task automatic gap(input int h);
    issue(4'hF, 7'h7F, h);
  endtask

  task automatic set_en(input logic v);
    EN = v;
    m_en = v;
    if (!v) m_seen = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dig_sel = 4'hF;
    seg_in = 7'h7F;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", hex_out, 0);
    check("rst_blank", blank_out, 4'hF);
    check("rst_err", err_out, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_selerr", sel_err, 0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: hex %0h blank %0h err %0h",
                 hex_out, blank_out, err_out);
      end else begin
        mon_f = exp_q.pop_front();
        check("frame_hex", hex_out, mon_f.hex);
        check("frame_blank", blank_out, mon_f.blank);
        check("frame_err", err_out, mon_f.err);
      end
    end
    if (sel_err === 1'b1) sel_pulses++;
  end

  initial begin
    logic [3:0] s;
    logic [6:0] g;
    int r, h;
    rst = 1'b1; EN = 1'b0; m_en = 1'b0; err_clr = 1'b0;
    dig_sel = 4'hF; seg_in = 7'h7F;
    @(posedge clk);
    #1;
    do_reset();
    set_en(1'b1);
    gap(4);

    // Plain scan 1,2,3,4
    for (int i = 0; i < 4; i++) issue(dsel(i), canon[i+1], 6);
    gap(8);

    // Too-fast toggling on digit 0 never captures
    for (int i = 0; i < 6; i++) issue(dsel(0), canon[5 + (i % 2)], 2);
    gap(6);

    // Blank and invalid digits
    issue(dsel(0), canon[7], 6);
    issue(dsel(1), canon[8], 6);
    issue(dsel(2), 7'h7F, 6);
    issue(dsel(3), 7'h55, 6);
    gap(8);

    // Multi-hot select
    issue(4'b1100, canon[1], 5);
    gap(6);
    check("sel_err_count", sel_pulses, sel_exp);

    // EN drop discards a partial frame
    for (int i = 0; i < 3; i++) issue(dsel(i), canon[9 + i], 6);
    gap(4);
    set_en(1'b0);
    gap(4);
    set_en(1'b1);
    gap(3);
    issue(dsel(3), canon[12], 6);
    gap(6);
    for (int i = 0; i < 3; i++) issue(dsel(i), canon[13 + i], 6);
    gap(8);

    // Reset mid-scan
    issue(dsel(0), canon[2], 6);
    issue(dsel(1), canon[3], 6);
    do_reset();
    set_en(1'b1);
    gap(3);
    issue(dsel(2), canon[4], 6);
    issue(dsel(3), canon[5], 6);
    gap(6);
    issue(dsel(0), canon[6], 6);
    issue(dsel(1), canon[7], 6);
    gap(8);

    // Error frame then clean frame
    issue(dsel(0), canon[1], 6);
    issue(dsel(1), 7'h55, 6);
    issue(dsel(2), canon[2], 6);
    issue(dsel(3), canon[3], 6);
    gap(8);
    for (int i = 0; i < 4; i++) issue(dsel(i), canon[8 + i], 6);
    gap(8);
`ifdef SEG7DEC_STICKY_ERR_EN
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_acc = 4'h0;
    check("err_clr", err_out, 0);
`endif

    // Randomized bus traffic
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        s = 4'hF;
      end else if (r == 1) begin
        s = 4'($urandom_range(0, 15));
        while (zeros(s) < 2) s = 4'($urandom_range(0, 15));
      end else begin
        s = dsel($urandom_range(0, 3));
      end
      r = $urandom_range(0, 9);
      if (r < 7) g = pat_tab[$urandom_range(0, 17)];
      else if (r == 7) g = 7'h7F;
      else g = 7'($urandom_range(0, 127));
      if (zeros(s) == 1 && {s, g} == last_bus) g = g ^ 7'h01;
      h = $urandom_range(1, 7);
      issue(s, g, h);
    end
    gap(4);
    for (int i = 0; i < 4; i++) issue(dsel(i), canon[i], 6);
    gap(20);

    check("frames_pending", exp_q.size(), 0);
    check("sel_err_total", sel_pulses, sel_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: no finish after 2000000 time units");
    $fatal(1, "timeout");
  end

endmodule
